// File: rtl/board_cursor_input.sv
// Player-input front end for tic-tac-toe: debounced buttons, 3x3 wrap-around cursor and a
// one-hot click vector to the game FSM that is refused on occupied cells.
//
// state   | meaning
// IDLE    | waiting for a select press; cuadro = 0
// HOLD    | cuadro = one-hot(sel) until the hold timer expires or sel becomes occupied
// RELEASE | click dropped; waiting for debounced select to go low
module board_cursor_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_select,
    input  logic [8:0] x,
    input  logic [8:0] o,
    output logic [8:0] cuadro,
    output logic [8:0] cursor,
    output logic [1:0] cursor_row,
    output logic [1:0] cursor_col,
    output logic       reject
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_SEL   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic logic [8:0] onehot9(input logic [3:0] idx);
        return 9'(1) << idx;
    endfunction

    logic [4:0]    btn_raw;
    logic [4:0]    sync1_q, sync2_q;
    logic [4:0]    db_q, db_d, db_prev_q;
    logic [4:0]    press;
    logic [DW-1:0] cnt_q [5];
    logic [DW-1:0] cnt_d [5];

    assign btn_raw = {btn_select, btn_right, btn_left, btn_down, btn_up};

    // Counter tracks consecutive cycles of disagreement; any agreement clears it.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign press = db_q & ~db_prev_q;

    logic [1:0] row_q, col_q, row_d, col_d;
    logic [8:0] cursor_q;
    logic [3:0] idx_cur, idx_nxt;
    logic [8:0] occ;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (press[B_UP] && !press[B_DOWN]) begin
            row_d = (row_q == 2'd0) ? 2'd2 : row_q - 2'd1;
        end else if (press[B_DOWN] && !press[B_UP]) begin
            row_d = (row_q == 2'd2) ? 2'd0 : row_q + 2'd1;
        end
        if (press[B_LEFT] && !press[B_RIGHT]) begin
            col_d = (col_q == 2'd0) ? 2'd2 : col_q - 2'd1;
        end else if (press[B_RIGHT] && !press[B_LEFT]) begin
            col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        end
    end

    assign idx_cur = {2'b00, row_q} * 4'd3 + {2'b00, col_q};
    assign idx_nxt = {2'b00, row_d} * 4'd3 + {2'b00, col_d};
    assign occ     = x | o;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            row_q    <= 2'd1;
            col_q    <= 2'd1;
            cursor_q <= 9'b000010000;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            cursor_q <= onehot9(idx_nxt);
        end
    end

    state_t        state_q;
    logic [3:0]    sel_q;
    logic [HW-1:0] hold_q;
    logic [8:0]    cuadro_q;
    logic          reject_q;

    // Select uses the pre-move index so a simultaneous move never retargets the click.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            hold_q   <= '0;
            cuadro_q <= '0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press[B_SEL]) begin
                        if (occ[idx_cur]) begin
                            reject_q <= 1'b1;
                        end else begin
                            sel_q    <= idx_cur;
                            cuadro_q <= onehot9(idx_cur);
                            hold_q   <= HW'(HOLD_CYCLES - 1);
                            state_q  <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (hold_q == '0 || occ[sel_q]) begin
                        cuadro_q <= '0;
                        state_q  <= RELEASE;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                RELEASE: begin
                    if (!db_q[B_SEL]) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cuadro_q <= '0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign cuadro     = cuadro_q;
    assign reject     = reject_q;
    assign cursor     = cursor_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule

// File: doc/board_cursor_input.md
# board_cursor_input

Player-input front end for the tic-tac-toe game. It debounces five push-buttons (up, down, left, right, select) and moves a 3x3 cursor with wrap-around. On select of an empty cell it drives the one-hot `cuadro[8:0]` click vector that the game state machine scans. It also reads back the board occupancy `x`/`o` from the game FSM, so it can refuse occupied cells and drop the click once the move has been taken.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a button level change (10 ms at 100 MHz).
- `HOLD_CYCLES`, default 16: maximum cycles `cuadro` stays asserted per click. Must be ≥ 12 so the FSM's nine-cell scan always sees it.

Ports:
- `clk_100MHz`  in  1  system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_select`  in  1 each  raw, asynchronous, active-high buttons.
- `x`  in  9  cells occupied by X, from the game FSM.
- `o`  in  9  cells occupied by O, from the game FSM.
- `cuadro`  out  9  one-hot click to the game FSM; registered; never more than one bit set.
- `cursor`  out  9  one-hot cursor position for display highlight; registered.
- `cursor_row`  out  2  cursor row, 0..2.
- `cursor_col`  out  2  cursor column, 0..2.
- `reject`  out  1  one-cycle pulse when select is pressed on an occupied cell.

## Operation
Buttons:
- Each button passes through a 2-flop synchronizer, then a per-button debounce counter.
- The debounced level changes only after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreement in between clears the counter.
- A rising edge of a debounced level produces a one-cycle press pulse. Releases produce nothing.

Cursor:
- `row` and `col` are each held in 0..2. Cell index = row*3 + col, and `cursor` = one-hot(index).
- up: row−1, 0 wraps to 2. down: row+1, 2 wraps to 0. left and right act the same way on `col`.
- up and down in the same cycle leave the row unchanged; left and right in the same cycle leave the column unchanged.
- A row move and a column move in the same cycle both apply.
- Moves are accepted in every state.

Click FSM (states IDLE, HOLD, RELEASE):
- IDLE: `cuadro` = 0.
  - On a select pulse where (x|o)[index] = 1: pulse `reject` and stay in IDLE.
  - On a select pulse on an empty cell: latch index into `sel`, set `cuadro` = one-hot(sel), load the hold counter with HOLD_CYCLES−1, go to HOLD.
  - When select and a move pulse occur in the same cycle, select uses the pre-move index.
- HOLD: `cuadro` stays constant. Leave for RELEASE with `cuadro` = 0 on whichever comes first:
  - the hold counter reaches 0;
  - `x[sel]` or `o[sel]` is observed at 1 (the move was accepted).
  - Otherwise decrement the hold counter.
- RELEASE: `cuadro` = 0. Stay in RELEASE at least one cycle and until debounced select is low, then go to IDLE.
- Select pulses in HOLD or RELEASE are ignored, with no `reject`.

Reset (`reset` = 0, asynchronous):
- row = col = 1, so `cursor` = 9'b000010000.
- `cuadro` = 0 and `reject` = 0.
- FSM in IDLE; all debounce counters and debounced levels cleared to 0.
- Asserting reset mid-HOLD drops `cuadro` immediately. After release, the first debounced edge counts normally.

## Timing
- Raw button to press pulse: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 edge-detect cycle.
- Move pulse in cycle t: `cursor`, `cursor_row` and `cursor_col` update at t+1.
- Select pulse in cycle t: `cuadro` (or `reject`) is valid at t+1.
- `cuadro` is high for exactly `HOLD_CYCLES` cycles, unless occupancy of `sel` is first seen in cycle k; then `cuadro` is 0 from k+1.
- Minimum gap between two clicks: one RELEASE cycle plus the select release and re-press debounce.
- `reject` is high for exactly one cycle per rejected press.

## Test plan
Run with `DEBOUNCE_CYCLES`=4 and `HOLD_CYCLES`=16.
1. Reset, then press right twice and down once → after the second right, `cursor_col` = 0 (wrapped); after down, `cursor_row` = 2; `cursor` = 9'b001000000.
2. Bounce `btn_up` with pulses of 1–3 cycles, then hold it for 10 cycles → exactly one up move; row 1→0.
3. With x = o = 0 and the cursor at center, press select → `cuadro` = 9'b000010000 for 16 cycles, then 0.
   - Holding select does not repeat the click. After release and re-press, a second click occurs.
4. During HOLD on cell 4, drive x[4] = 1 at HOLD cycle 5 → `cuadro` = 0 on the next cycle.
   - A following select on cell 4 → `reject` is one cycle high and `cuadro` stays 0.
5. Press select and left in the same debounced cycle with the cursor at (0,0) → `cuadro` = 9'b000000001 and `cursor_col` becomes 2.
   - Press up and down together → row unchanged.
6. Assert `reset` low at HOLD cycle 3 → `cuadro` = 0 asynchronously and `cursor` = 9'b000010000. After release, a select produces a normal 16-cycle click.
